// File: rtl/apb_slave_mem.sv
// APB slave backed by a DEPTH x 32-bit register memory, with a synchronous active-high reset.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer. Left undefined, every transfer completes in its first access cycle.
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef APB_SLV_WAIT_EN
    localparam int unsigned W_EFF = WAIT_CYCLES;
    localparam int unsigned CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
    // Wait states are compiled out, so WAIT_CYCLES has no effect here.
    localparam int unsigned W_EFF = 0 * WAIT_CYCLES;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef APB_SLV_WAIT_EN
        S_WAIT   = 2'd1,
`endif
        S_ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   idx_q;
    logic            err_q, wr_q;
    logic [31:0]     prdata_q, prdata_d;
    logic            pready_q, pready_d;
    logic            pslverr_q, pslverr_d;
    logic            cap, mem_we;
`ifdef APB_SLV_WAIT_EN
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    // Out-of-range covers addresses below BASE_ADDR, because the subtraction wraps to a large value.
    logic [31:0]   offset, word;
    logic [AW-1:0] idx_now;
    logic          err_now;
    assign offset  = paddr - BASE_ADDR;
    assign word    = offset >> 2;
    assign idx_now = word[AW-1:0];
    assign err_now = (paddr[1:0] != 2'b00) || (word >= DEPTH);

    always_comb begin
        state_d  = state_q;
        prdata_d = prdata_q;
        cap      = 1'b0;
        mem_we   = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    cap = 1'b1;
                    if (W_EFF == 0) begin
                        state_d = S_ACCESS;
                        if (!pwrite) prdata_d = err_now ? '0 : mem_q[idx_now];
                    end else begin
`ifdef APB_SLV_WAIT_EN
                        state_d = S_WAIT;
                        cnt_d   = CW'(W_EFF);
`endif
                    end
                end
            end
`ifdef APB_SLV_WAIT_EN
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_ACCESS;
                    if (!wr_q) prdata_d = err_q ? '0 : mem_q[idx_q];
                end
            end
`endif
            S_ACCESS: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    state_d = S_IDLE;
                    mem_we  = wr_q && !err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pready_d  = (state_d == S_ACCESS);
        pslverr_d = pready_d && (cap ? err_now : err_q);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
            if (cap) begin
                idx_q <= idx_now;
                err_q <= err_now;
                wr_q  <= pwrite;
            end
            if (mem_we) mem_q[idx_q] <= pwdata;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem.
// The expected handshake latency follows APB_SLV_WAIT_EN.
module tb_apb_slave_mem;
`ifdef APB_SLV_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        aclk = 1'b0;
    logic        areset, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;

    apb_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
        .aclk(aclk), .areset(areset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transfer starting at a negedge: setup, then access until pready is high, then completion.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        int n;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge aclk);
        penable = 1'b1;
        n = 1;
        while (!pready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("ready_latency", 32'(n), 32'(1 + W));
        rd = prdata;
        er = pslverr;
        @(negedge aclk);
        chk("ready_fall", {31'b0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          t0;

    initial begin
        areset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(negedge aclk);
        chk("rst_pready",  {31'b0, pready},  32'd0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
        chk("rst_prdata",  prdata,           32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Read of a freshly reset word.
        xfer(1'b0, 32'h0, 32'h0, rd, er);
        chk("rd0_data", rd, 32'h0);
        chk("rd0_err",  {31'b0, er}, 32'd0);

        // Write followed by a read of the same word.
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
        chk("wr10_err", {31'b0, er}, 32'd0);
        xfer(1'b0, 32'h10, 32'h0, rd, er);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err",  {31'b0, er}, 32'd0);

        // Error writes: index out of range and misaligned; prdata holds across writes.
        xfer(1'b1, 32'h100, 32'h1234_5678, rd, er);
        chk("wr100_err",   {31'b0, er}, 32'd1);
        chk("prdata_hold", rd, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h2, 32'h1234_5678, rd, er);
        chk("wr2_err", {31'b0, er}, 32'd1);
        xfer(1'b0, 32'h0, 32'h0, rd, er);
        chk("rd0_after_err", rd, 32'h0);
        xfer(1'b0, 32'h100, 32'h0, rd, er);
        chk("rd100_data", rd, 32'h0);
        chk("rd100_err",  {31'b0, er}, 32'd1);
        chk("idle_pslverr", {31'b0, pslverr}, 32'd0);

        // Last valid word.
        xfer(1'b1, 32'hFC, 32'hCAFE_F00D, rd, er);
        xfer(1'b0, 32'hFC, 32'h0, rd, er);
        chk("rdFC_data", rd, 32'hCAFE_F00D);
        chk("rdFC_err",  {31'b0, er}, 32'd0);

        // Master abort: psel dropped right after the setup phase.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hA5A5_A5A5;
        @(negedge aclk);
        chk("abort_first_rdy", {31'b0, pready}, (W == 0) ? 32'd1 : 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge aclk);
        chk("abort_rdy", {31'b0, pready}, 32'd0);
        repeat (3) @(negedge aclk);
        chk("abort_rdy_later", {31'b0, pready}, 32'd0);
        xfer(1'b0, 32'h8, 32'h0, rd, er);
        chk("rd8_after_abort", rd, 32'h0);

        // penable without a setup phase is ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h5555_5555;
        repeat (3) @(negedge aclk);
        chk("no_setup_rdy", {31'b0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge aclk);
        xfer(1'b0, 32'h0, 32'h0, rd, er);
        chk("rd0_no_setup", rd, 32'h0);

        // Reset during the access phase of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hFFFF_FFFF;
        @(negedge aclk);
        penable = 1'b1; areset = 1'b1;
        @(negedge aclk);
        chk("rst_mid_rdy", {31'b0, pready}, 32'd0);
        areset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge aclk);
        xfer(1'b0, 32'h4, 32'h0, rd, er);
        chk("rd4_after_rst", rd, 32'h0);
        xfer(1'b0, 32'h10, 32'h0, rd, er);
        chk("rd10_cleared", rd, 32'h0);

        // Back-to-back writes then reads.
        t0 = cyc_cnt;
        for (int i = 0; i < 8; i++) xfer(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h11, rd, er);
        chk("b2b_wr_cycles", 32'(cyc_cnt - t0), 32'(8 * (2 + W)));
        t0 = cyc_cnt;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, rd, er);
            chk("b2b_rd_data", rd, 32'h1000_0000 + 32'(i) * 32'h11);
        end
        chk("b2b_rd_cycles", 32'(cyc_cnt - t0), 32'(8 * (2 + W)));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
